// File: rtl/dac_scheduler.sv
// dac_scheduler
// Shares one 4-channel, 12-bit SPI DAC between four sample requesters.
// Requesters are arbitrated round-robin. For each grant the requester's sample
// is captured and sent as a 32-bit write-and-update frame, MSB first.
// The DAC clear is also sequenced after reset.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous reset, active low (0 = reset)
//   req      - per-channel request, bit n = channel n
//   sample   - channel n sample at bits [12n+11:12n]
//   ack      - one-cycle pulse: channel n's sample was captured
//   spi_mosi - serial data to the DAC
//   spi_sck  - serial clock to the DAC
//   dac_cs   - DAC chip select, active low
//   dac_clr  - DAC clear, active low
//   busy     - high whenever the scheduler is not idle
module dac_scheduler #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned CS_GAP     = 2,
    parameter int unsigned CLR_CYCLES = 4,
    parameter logic [3:0]  CMD        = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [47:0] sample,
    output logic [3:0]  ack,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        dac_cs,
    output logic        dac_clr,
    output logic        busy
);

    localparam logic [1:0] ST_CLR   = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  ack_q, ack_d;
    logic        mosi_q, mosi_d;
    logic        sck_q, sck_d;
    logic        cs_q, cs_d;
    logic        clr_q, clr_d;
    logic        busy_q, busy_d;

    logic [1:0]  gnt;
    logic [1:0]  idx;
    logic        gnt_valid;
    logic [11:0] gnt_data;
    logic [31:0] gnt_frame;

    // Round-robin search starting at the pointer. The loop runs from the
    // farthest offset down to offset 0, so the closest requester wins.
    always_comb begin
        gnt       = ptr_q;
        idx       = ptr_q;
        gnt_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                gnt       = idx;
                gnt_valid = 1'b1;
            end
        end
    end

    assign gnt_data  = sample[12*int'(gnt) +: 12];
    assign gnt_frame = {8'h00, CMD, 2'b00, gnt, gnt_data, 4'h0};

    // Next-state logic. cnt_q is reused for three jobs: the clear-hold
    // count, the SCK divider and the chip-select gap count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ptr_d   = ptr_q;
        ack_d   = 4'b0000;
        mosi_d  = mosi_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        clr_d   = clr_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLR: begin
                if (cnt_q == CLR_LAST) begin
                    clr_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IDLE: begin
                if (gnt_valid) begin
                    shreg_d = gnt_frame;
                    mosi_d  = gnt_frame[31];
                    sck_d   = 1'b0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    ack_d   = 4'b0001 << gnt;
                    ptr_d   = gnt + 2'd1;
                    cnt_d   = 8'd0;
                    bit_d   = 5'd31;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else if (bit_q == 5'd0) begin
                        // The last high phase ends the frame. SCK drops and CS
                        // rises on the same edge.
                        sck_d   = 1'b0;
                        cs_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = ST_GAP;
                    end else begin
                        // On the falling edge, present the next bit so it has
                        // a full low phase to settle before the rising edge.
                        sck_d   = 1'b0;
                        bit_d   = bit_q - 5'd1;
                        shreg_d = {shreg_q[30:0], 1'b0};
                        mosi_d  = shreg_q[30];
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_CLR;
        endcase
    end

    // State and output registers. Reset aborts any frame in flight and
    // restarts the clear sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_CLR;
            cnt_q   <= 8'd0;
            bit_q   <= 5'd0;
            shreg_q <= 32'd0;
            ptr_q   <= 2'd0;
            ack_q   <= 4'b0000;
            mosi_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            clr_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            mosi_q  <= mosi_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign spi_mosi = mosi_q;
    assign spi_sck  = sck_q;
    assign dac_cs   = cs_q;
    assign dac_clr  = clr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dac_scheduler.sv
// tb_dac_scheduler
// Bench for dac_scheduler.
// dut0 uses the default parameters and dut1 uses CLK_DIV=1.
// Both share the same clock and reset.
// Expected frames are queued when a request is driven. The per-DUT monitors
// rebuild each frame from the pins and check it against the queue.
`timescale 1ns/1ps
module tb_dac_scheduler;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int SPACING = 64*CLK_DIV + CS_GAP + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req0, req1;
    logic [47:0] sample0, sample1;
    logic [3:0]  ack0, ack1;
    logic        spi_mosi0, spi_sck0, dac_cs0, dac_clr0, busy0;
    logic        spi_mosi1, spi_sck1, dac_cs1, dac_clr1, busy1;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] frame;
        int          div;
    } exp_t;
    exp_t sbQ[$];

    typedef struct {
        int          ch;
        logic [11:0] data;
        logic [31:0] frame;
    } vec_t;
    vec_t vecs[4];

    dac_scheduler dut0 (
        .clk(clk), .rst(rst), .req(req0), .sample(sample0), .ack(ack0),
        .spi_mosi(spi_mosi0), .spi_sck(spi_sck0), .dac_cs(dac_cs0),
        .dac_clr(dac_clr0), .busy(busy0)
    );

    dac_scheduler #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .sample(sample1), .ack(ack1),
        .spi_mosi(spi_mosi1), .spi_sck(spi_sck1), .dac_cs(dac_cs1),
        .dac_clr(dac_clr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkFrame(input string name, input logic [31:0] word, input int bits, input int csLow);
        exp_t e;
        checkOutput({name, "_sbNonEmpty"}, 32'(sbQ.size() != 0), 1);
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput({name, "_word"}, word, e.frame);
            checkOutput({name, "_bits"}, bits, 32);
            checkOutput({name, "_csLow"}, csLow, 64*e.div);
        end
    endtask

    // Monitor for dut0: rebuilds frames on SCK rising edges seen at negedge clk
    logic [31:0] word0;
    int          bits0, csLow0, csRise0;
    bit          inFrame0, prevSck0;
    logic [3:0]  prevAck0;
    always @(negedge clk) begin
        if (!rst) begin
            inFrame0 = 1'b0;
            prevSck0 = 1'b0;
            prevAck0 = 4'b0;
        end else begin
            if (ack0 != 4'b0) begin
                checkOutput("ack0Onehot", 32'($onehot(ack0)), 1);
                checkOutput("ack0Pulse", 32'(prevAck0 != 4'b0), 0);
            end
            prevAck0 = ack0;
            if (!dac_cs0) begin
                if (!inFrame0) begin
                    inFrame0 = 1'b1;
                    word0    = 32'd0;
                    bits0    = 0;
                    csLow0   = 0;
                end
                csLow0++;
                if (spi_sck0 && !prevSck0) begin
                    word0 = {word0[30:0], spi_mosi0};
                    bits0++;
                end
            end else if (inFrame0) begin
                inFrame0 = 1'b0;
                csRise0  = cyc;
                checkFrame("frame0", word0, bits0, csLow0);
            end
            prevSck0 = spi_sck0;
        end
    end

    // Monitor for dut1
    logic [31:0] word1;
    int          bits1, csLow1;
    bit          inFrame1, prevSck1;
    always @(negedge clk) begin
        if (!rst) begin
            inFrame1 = 1'b0;
            prevSck1 = 1'b0;
        end else begin
            if (!dac_cs1) begin
                if (!inFrame1) begin
                    inFrame1 = 1'b1;
                    word1    = 32'd0;
                    bits1    = 0;
                    csLow1   = 0;
                end
                csLow1++;
                if (spi_sck1 && !prevSck1) begin
                    word1 = {word1[30:0], spi_mosi1};
                    bits1++;
                end
            end else if (inFrame1) begin
                inFrame1 = 1'b0;
                checkFrame("frame1", word1, bits1, csLow1);
            end
            prevSck1 = spi_sck1;
        end
    end

    task automatic applyStimulus(input int sel, input logic [3:0] r, input logic [47:0] s);
        if (sel == 0) begin
            req0 = r;
            sample0 = s;
        end else begin
            req1 = r;
            sample1 = s;
        end
    endtask

    task automatic waitAck(input int sel, input int bound, output logic [3:0] a, output int t);
        a = 4'b0;
        t = cyc;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            a = (sel == 0) ? ack0 : ack1;
            t = cyc;
            if (a != 4'b0) break;
        end
    endtask

    task automatic waitIdle(input int sel, input int bound, output int t, output bit timedOut);
        timedOut = 1'b1;
        t = cyc;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            t = cyc;
            if (((sel == 0) ? busy0 : busy1) == 1'b0) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic clrSequence(output int lowCycles, output logic [3:0] ackSeen);
        lowCycles = 0;
        ackSeen = 4'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ackSeen |= ack0 | ack1;
            if (dac_clr0) break;
            lowCycles++;
        end
    endtask

    function automatic logic [31:0] makeFrame(input int ch, input logic [11:0] data);
        return {8'h00, 4'h3, 2'b00, 2'(ch), data, 4'h0};
    endfunction

    initial begin
        logic [3:0]  a;
        logic [47:0] s;
        int          t, tPrev, lowCycles, gapT;
        bit          to;
        logic [3:0]  ackSeen;
        int          rrOrder[5] = '{0, 1, 2, 3, 0};

        vecs[0] = '{0, 12'h123, 32'h00301230};
        vecs[1] = '{3, 12'h5A5, 32'h00335A50};
        vecs[2] = '{1, 12'hFFF, 32'h0031FFF0};
        vecs[3] = '{2, 12'hABC, 32'h0032ABC0};

        rst = 1'b0;
        applyStimulus(0, 4'b0, 48'd0);
        applyStimulus(1, 4'b0, 48'd0);
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", {dac_cs0, spi_sck0, spi_mosi0, dac_clr0, busy0, ack0}, 9'b1_0_0_0_1_0000);

        // Clear sequence after release, with no requests pending
        @(posedge clk);
        #1 rst = 1'b1;
        clrSequence(lowCycles, ackSeen);
        checkOutput("clrLowCycles", lowCycles, 4);
        checkOutput("clrNoAck", ackSeen, 0);
        checkOutput("idleOutputs", {dac_cs0, spi_sck0, busy0, ack0, dac_clr1}, 8'b1_0_0_0000_1);

        // Single-channel vectors. The last one leaves the pointer at 3.
        for (int i = 0; i < 4; i++) begin
            s = 48'd0;
            s[12*vecs[i].ch +: 12] = vecs[i].data;
            sbQ.push_back('{vecs[i].frame, CLK_DIV});
            applyStimulus(0, 4'b0001 << vecs[i].ch, s);
            waitAck(0, 50, a, t);
            checkOutput("vecAck", a, 4'b0001 << vecs[i].ch);
            req0 = 4'b0;
            waitIdle(0, 400, gapT, to);
            checkOutput("vecIdleTimeout", to, 0);
            checkOutput("vecCsGap", gapT - csRise0, CS_GAP);
        end

        // With the pointer at 3, req=0011 grants 0 then 1
        s = 48'd0;
        s[11:0]  = 12'h111;
        s[23:12] = 12'h222;
        sbQ.push_back('{32'h00301110, CLK_DIV});
        sbQ.push_back('{32'h00312220, CLK_DIV});
        applyStimulus(0, 4'b0011, s);
        waitAck(0, 50, a, t);
        checkOutput("ptr3First", a, 4'b0001);
        req0[0] = 1'b0;
        waitAck(0, 300, a, t);
        checkOutput("ptr3Second", a, 4'b0010);
        req0 = 4'b0;
        waitIdle(0, 400, t, to);
        checkOutput("ptr3Idle", to, 0);

        // The pointer is now 2, so req=1001 grants 3 then 0
        s = 48'd0;
        s[47:36] = 12'h333;
        s[11:0]  = 12'h444;
        sbQ.push_back('{32'h00333330, CLK_DIV});
        sbQ.push_back('{32'h00304440, CLK_DIV});
        applyStimulus(0, 4'b1001, s);
        waitAck(0, 50, a, t);
        checkOutput("wrapFirst", a, 4'b1000);
        req0[3] = 1'b0;
        waitAck(0, 300, a, t);
        checkOutput("wrapSecond", a, 4'b0001);
        req0 = 4'b0;
        waitIdle(0, 400, t, to);
        checkOutput("wrapIdle", to, 0);

        // Reset in the middle of a frame; this frame is never expected to complete
        s = 48'd0;
        s[35:24] = 12'h777;
        applyStimulus(0, 4'b0100, s);
        waitAck(0, 50, a, t);
        checkOutput("abortAck", a, 4'b0100);
        req0 = 4'b0;
        repeat (64) @(negedge clk);
        checkOutput("abortMidFrameCs", dac_cs0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 checkOutput("abortOutputs", {dac_cs0, spi_sck0, dac_clr0, busy0, ack0}, 8'b1_0_0_1_0000);
        s = {12'hD44, 12'hC33, 12'hB22, 12'hA11};
        for (int k = 0; k < 5; k++)
            sbQ.push_back('{makeFrame(rrOrder[k], s[12*rrOrder[k] +: 12]), CLK_DIV});
        applyStimulus(0, 4'b1111, s);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        clrSequence(lowCycles, ackSeen);
        checkOutput("reClrLowCycles", lowCycles, 4);
        checkOutput("reClrNoAck", ackSeen, 0);

        // Continuous requests on all four channels rotate 0,1,2,3,0
        tPrev = 0;
        for (int k = 0; k < 5; k++) begin
            waitAck(0, 300, a, t);
            checkOutput("rrAck", a, 4'b0001 << rrOrder[k]);
            if (k > 0) checkOutput("rrSpacing", t - tPrev, SPACING);
            tPrev = t;
        end
        req0 = 4'b0;
        waitIdle(0, 400, t, to);
        checkOutput("rrIdle", to, 0);

        // Full-scale and zero codes at CLK_DIV=1
        s = 48'd0;
        s[23:12] = 12'hFFF;
        sbQ.push_back('{32'h0031FFF0, 1});
        applyStimulus(1, 4'b0010, s);
        waitAck(1, 50, a, t);
        checkOutput("div1AckFFF", a, 4'b0010);
        req1 = 4'b0;
        waitIdle(1, 200, t, to);
        checkOutput("div1IdleFFF", to, 0);
        s[23:12] = 12'h000;
        sbQ.push_back('{32'h00310000, 1});
        applyStimulus(1, 4'b0010, s);
        waitAck(1, 50, a, t);
        checkOutput("div1Ack000", a, 4'b0010);
        req1 = 4'b0;
        waitIdle(1, 200, t, to);
        checkOutput("div1Idle000", to, 0);

        repeat (2) @(negedge clk);
        checkOutput("sbDrained", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
